// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types for the pipeline hazard controller
package hazard_pkg;
   localparam int REG_AW_DEF = 5;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
   typedef enum logic {RUN, WAIT} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, register write/flush controls out
interface pipe_hazard_ctrl_if import hazard_pkg::*; #(parameter int REG_AW = REG_AW_DEF);
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
   logic mem_regwrite, mem_memread, mem_req, wb_regwrite, branch_taken;
   fwd_sel_t fwd_a, fwd_b;
   logic pc_write, ifid_write, idex_write, exmem_write;
   logic ifid_flush, idex_flush, exmem_flush, memwb_bubble;
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
             mem_rd, mem_regwrite, mem_memread, mem_req, wb_rd, wb_regwrite, branch_taken,
      input  fwd_a, fwd_b, pc_write, ifid_write, idex_write, exmem_write,
             ifid_flush, idex_flush, exmem_flush, memwb_bubble
   );
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
             mem_rd, mem_regwrite, mem_memread, mem_req, wb_rd, wb_regwrite, branch_taken,
      output fwd_a, fwd_b, pc_write, ifid_write, idex_write, exmem_write,
             ifid_flush, idex_flush, exmem_flush, memwb_bubble
   );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// fwd_select: priority forwarding select for one ALU operand
module fwd_select import hazard_pkg::*; #(parameter int REG_AW = REG_AW_DEF) (
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              mem_regwrite,
   input  logic              mem_memread,
   input  logic              wb_regwrite,
   output fwd_sel_t          sel
);
   // EX/MEM wins over WB; a load in EX/MEM has no data yet so it is skipped
   always_comb sel = (mem_regwrite && !mem_memread && mem_rd != '0 && mem_rd == rs) ? FWD_MEM :
                     (wb_regwrite && wb_rd != '0 && wb_rd == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use stall, branch flush and memory freeze; HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl import hazard_pkg::*; #(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int MEM_LAT = 1
`ifdef HAZARD_PERF_EN
 , parameter int CNT_W   = 32
`endif
)(
   input  logic clk,
   input  logic reset,
   pipe_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
 , output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
`endif
);
   localparam int CW = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic freeze, live, lu, br, stall;
   fwd_sel_t sel_a, sel_b;
   fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
      .rs(bus.ex_rs1), .mem_rd(bus.mem_rd), .wb_rd(bus.wb_rd), .mem_regwrite(bus.mem_regwrite),
      .mem_memread(bus.mem_memread), .wb_regwrite(bus.wb_regwrite), .sel(sel_a)
   );
   fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
      .rs(bus.ex_rs2), .mem_rd(bus.mem_rd), .wb_rd(bus.wb_rd), .mem_regwrite(bus.mem_regwrite),
      .mem_memread(bus.mem_memread), .wb_regwrite(bus.wb_regwrite), .sel(sel_b)
   );
   // memory-wait state and remaining freeze cycles
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   // next state plus all pipeline controls; everything is held off while reset is low
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      freeze   = 1'b0;
      if (state == RUN) begin
         if (bus.mem_req && MEM_LAT > 1) begin
            freeze   = 1'b1;
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
         end
      end else if (cnt != '0) begin
         freeze = 1'b1;
         cnt_nx = cnt - 1'b1;
      end else begin
         state_nx = RUN;
      end
      live  = state == RUN && !freeze;
      lu    = live && bus.ex_memread && bus.ex_rd != '0 &&
              ((bus.id_use_rs1 && bus.ex_rd == bus.id_rs1) || (bus.id_use_rs2 && bus.ex_rd == bus.id_rs2));
      br    = live && bus.branch_taken;
      stall = lu && !br;
      bus.fwd_a        = reset ? sel_a : FWD_RF;
      bus.fwd_b        = reset ? sel_b : FWD_RF;
      bus.pc_write     = reset && !freeze && !stall;
      bus.ifid_write   = reset && !freeze && !stall;
      bus.idex_write   = reset && !freeze;
      bus.exmem_write  = reset && !freeze;
      bus.ifid_flush   = reset && br;
      bus.idex_flush   = reset && (br || stall);
      bus.exmem_flush  = reset && br;
      bus.memwb_bubble = reset && freeze;
   end
`ifdef HAZARD_PERF_EN
   // saturating counts of stall/freeze cycles and taken-branch flushes
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if ((stall || freeze) && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
         if (br && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
`endif
   a_mem_br: assert property (@(posedge clk) disable iff (!reset) !(bus.mem_req && bus.branch_taken))
      else $error("mem_req and branch_taken asserted together");
endmodule
